// File: rtl/frame_rd_ctrl_if.sv
// SDRAM read-port bundle between the VGA frame reader and the SDRAM controller.
//   rd_req  : burst read request, held until rd_ack
//   rd_bank : SDRAM bank of the request
//   rd_addr : start word address of the burst
//   rd_len  : burst length in words
//   rd_ack  : controller accepted the request (one-cycle pulse)
//   rd_done : last word of the burst written to the FIFO (one-cycle pulse)
interface frame_rd_ctrl_if #(
  parameter int unsigned ADDR_W = 22
);
  logic              rd_req;
  logic [1:0]        rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic [8:0]        rd_len;
  logic              rd_ack;
  logic              rd_done;

  modport master (
    output rd_req, rd_bank, rd_addr, rd_len,
    input  rd_ack, rd_done
  );

  modport slave (
    input  rd_req, rd_bank, rd_addr, rd_len,
    output rd_ack, rd_done
  );
endinterface

// File: rtl/frame_rd_ctrl.sv
// VGA-side frame reader. On a frame_start rising edge it latches the display bank and
// fetches one whole frame as a sequence of SDRAM burst reads, one outstanding at a time,
// only while the VGA FIFO is below the fill threshold. At end of frame vga_rise is held
// for DONE_HOLD cycles so the bank arbiter can hand over a newer bank.
// Ports:
//   clk, rst_133   : 133 MHz clock, asynchronous active-low reset
//   frame_start    : frame start level from VGA timing (asynchronous, synchronised here)
//   vga_bank       : bank currently assigned to the display path
//   fifo_usedw     : VGA FIFO write-side fill level
//   rd             : SDRAM read-port bundle (master side)
//   vga_rise       : frame-read-complete indication to the arbiter
//   busy           : FSM not idle
//   frame_overrun  : sticky, frame_start edge arrived while busy
module frame_rd_ctrl #(
  parameter int unsigned H_ACT       = 640,
  parameter int unsigned V_ACT       = 480,
  parameter int unsigned BURST_LEN   = 256,
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned USEDW_W     = 10,
  parameter int unsigned FILL_THRESH = 512,
  parameter int unsigned DONE_HOLD   = 4
) (
  input  logic               clk,
  input  logic               rst_133,
  input  logic               frame_start,
  input  logic [1:0]         vga_bank,
  input  logic [USEDW_W-1:0] fifo_usedw,
  frame_rd_ctrl_if.master    rd,
  output logic               vga_rise,
  output logic               busy,
  output logic               frame_overrun
);

  localparam int unsigned FRAME_WORDS = H_ACT * V_ACT;
  localparam int unsigned NBURST      = (FRAME_WORDS + BURST_LEN - 1) / BURST_LEN;
  localparam int unsigned LAST_REM    = FRAME_WORDS % BURST_LEN;
  localparam int unsigned LAST_LEN    = (LAST_REM == 0) ? BURST_LEN : LAST_REM;
  localparam int unsigned CNT_W       = (NBURST > 1) ? $clog2(NBURST) : 1;
  localparam int unsigned HOLD_W      = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

  localparam logic [CNT_W-1:0]   LAST_BURST = CNT_W'(NBURST - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(DONE_HOLD - 1);
  localparam logic [8:0]         FULL_LEN9  = 9'(BURST_LEN);
  localparam logic [8:0]         LAST_LEN9  = 9'(LAST_LEN);
  // One extra bit so a threshold of 2**USEDW_W still compares correctly.
  localparam logic [USEDW_W:0]   THRESH     = (USEDW_W + 1)'(FILL_THRESH);

  typedef enum logic [2:0] {
    StIdle,
    StWaitSpace,
    StReq,
    StWaitDone,
    StFinish
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         bank_q, bank_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [8:0]         len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               overrun_q, overrun_d;
  logic               fs_meta_q, fs_sync_q, fs_prev_q;

  logic start_edge;
  logic finish_last;
  logic start_ok;
  logic space_ok;

  assign start_edge  = fs_sync_q & ~fs_prev_q;
  assign finish_last = (state_q == StFinish) && (hold_q == HOLD_LAST);
  // An edge landing on the last FINISH cycle starts the next frame rather than being dropped.
  assign start_ok    = start_edge && ((state_q == StIdle) || finish_last);
  assign space_ok    = {1'b0, fifo_usedw} < THRESH;

  always_ff @(posedge clk or negedge rst_133) begin
    if (!rst_133) begin
      fs_meta_q <= 1'b0;
      fs_sync_q <= 1'b0;
      fs_prev_q <= 1'b0;
      state_q   <= StIdle;
      bank_q    <= 2'b00;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      fs_meta_q <= frame_start;
      fs_sync_q <= fs_meta_q;
      fs_prev_q <= fs_sync_q;
      state_q   <= state_d;
      bank_q    <= bank_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    overrun_d = overrun_q;

    unique case (state_q)
      StIdle: ;
      StWaitSpace: begin
        len_d = (cnt_q == LAST_BURST) ? LAST_LEN9 : FULL_LEN9;
        if (space_ok) state_d = StReq;
      end
      StReq: begin
        // A same-cycle rd_done is meaningless here; only the ack is taken.
        if (rd.rd_ack) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (rd.rd_done) begin
          addr_d  = addr_q + ADDR_W'(len_q);
          cnt_d   = cnt_q + 1'b1;
          hold_d  = '0;
          state_d = (cnt_q == LAST_BURST) ? StFinish : StWaitSpace;
        end
      end
      StFinish: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HOLD_LAST) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (start_ok) begin
      bank_d  = vga_bank;
      addr_d  = '0;
      cnt_d   = '0;
      state_d = StWaitSpace;
    end else if (start_edge) begin
      overrun_d = 1'b1;
    end
  end

  assign rd.rd_req     = (state_q == StReq);
  assign rd.rd_bank    = bank_q;
  assign rd.rd_addr    = addr_q;
  assign rd.rd_len     = len_q;
  assign vga_rise      = (state_q == StFinish);
  assign busy          = (state_q != StIdle);
  assign frame_overrun = overrun_q;

endmodule

// File: doc/frame_rd_ctrl.md
Name: frame_rd_ctrl

Overview:
- VGA-side frame reader. Issues SDRAM burst read requests for one complete frame from the bank currently assigned to the display path.
- Keeps the downstream VGA read FIFO topped up.
- At end of frame, signals completion back to the triple-buffer bank arbiter on vga_rise so a newer full bank can be handed over.
- Sits between the bank arbiter, the SDRAM controller read port and the VGA line FIFO, all in the 133 MHz clk domain.

Parameters:
- H_ACT, 640, active pixels (16-bit words) per line
- V_ACT, 480, active lines per frame
- BURST_LEN, 256, maximum words per SDRAM read burst; power of two
- ADDR_W, 22, word address width within one SDRAM bank
- USEDW_W, 10, width of FIFO fill-level input
- FILL_THRESH, 512, request a burst only while FIFO fill level is below this
- DONE_HOLD, 4, cycles vga_rise is held high (minimum 2, so the arbiter's 2-flop edge detector catches it)

Ports:
- clk, in, 1, 133 MHz system clock
- rst_133, in, 1, asynchronous active-low reset
- frame_start, in, 1, level from VGA timing; a rising edge means start fetching a new frame; may be asynchronous
- vga_bank, in, 2, bank index assigned to the display path by the arbiter
- fifo_usedw, in, USEDW_W, VGA FIFO write-side fill level
- rd_req, out, 1, burst read request to the SDRAM controller
- rd_bank, out, 2, SDRAM bank for the request
- rd_addr, out, ADDR_W, start word address of the burst
- rd_len, out, 9, burst length in words (1..BURST_LEN)
- rd_ack, in, 1, controller accepted the request; single-cycle pulse
- rd_done, in, 1, last word of the accepted burst written to the FIFO; single-cycle pulse
- vga_rise, out, 1, frame-read-complete indication to the bank arbiter
- busy, out, 1, high in any state other than IDLE
- frame_overrun, out, 1, sticky error flag: frame_start edge arrived while busy

Behaviour:
- Reset values (async, rst_133 low): state IDLE, rd_req 0, rd_bank 2'b00, rd_addr 0, rd_len 0, vga_rise 0, busy 0, frame_overrun 0, internal counters 0. Reset mid-burst aborts immediately; no cleanup of outstanding SDRAM reads.
- frame_start path: two-flop synchronizer, then edge detect. start_edge = s1 & ~s2, so the edge is seen 2 cycles after the input rises.
- Frame size:
  - FRAME_WORDS = H_ACT*V_ACT.
  - NBURST = ceil(FRAME_WORDS/BURST_LEN).
  - LAST_LEN = FRAME_WORDS mod BURST_LEN, or BURST_LEN if the remainder is 0.
- IDLE:
  - On start_edge: latch vga_bank into rd_bank, set rd_addr 0 and burst_cnt 0, go to WAIT_SPACE.
  - rd_bank stays constant for the whole frame even if vga_bank changes.
- WAIT_SPACE:
  - If fifo_usedw < FILL_THRESH: go to REQ.
  - rd_len = LAST_LEN when burst_cnt == NBURST-1, else BURST_LEN.
- REQ:
  - rd_req = 1, with rd_bank, rd_addr and rd_len stable.
  - rd_req stays high until rd_ack is sampled high. rd_req drops in the cycle after rd_ack; then go to WAIT_DONE.
  - No timeout.
- WAIT_DONE:
  - On rd_done: rd_addr += rd_len (modulo 2^ADDR_W), burst_cnt += 1.
  - If burst_cnt was NBURST-1: go to FINISH, else go to WAIT_SPACE.
  - rd_done outside WAIT_DONE is ignored.
- FINISH: vga_rise = 1 for exactly DONE_HOLD cycles, then IDLE. vga_rise is 0 in all other states.
- Only one burst is outstanding at a time; a new request is never issued before the previous rd_done.
- start_edge while busy (including FINISH): ignored for fetching; frame_overrun set to 1 and held until reset.
- start_edge in the same cycle the FSM enters IDLE from FINISH: not lost; it is treated as the IDLE start.
- rd_ack and rd_done in the same cycle while in REQ: rd_ack is taken; rd_done is ignored because the controller must not complete before acking.
- Width rule: ADDR_W must be ≥ ceil(log2(FRAME_WORDS)); rd_addr never wraps within a legal frame.

Test Plan:
- Basic frame (H_ACT=16, V_ACT=4, BURST_LEN=16, fifo_usedw=0, vga_bank=2'b10):
  - Stimulus: frame_start rises.
  - Required: 4 requests with rd_addr 0,16,32,48, rd_len 16, rd_bank 2'b10; vga_rise high for 4 cycles after the 4th rd_done; busy then drops.
- Partial last burst (H_ACT=20, V_ACT=4, BURST_LEN=32):
  - Required: rd_len sequence 32,32,16; rd_addr sequence 0,32,64.
- FIFO throttle:
  - Stimulus: hold fifo_usedw=600 (above FILL_THRESH=512) for 50 cycles.
  - Required: rd_req stays 0 throughout; first rd_req appears 1 cycle after fifo_usedw drops to 511.
- Bank latch and overrun:
  - Stimulus: change vga_bank mid-frame and pulse frame_start while busy.
  - Required: rd_bank unchanged for all bursts; frame_overrun=1 and stays 1; no extra bursts.
- Delayed ack:
  - Stimulus: rd_ack arrives 7 cycles after rd_req rises.
  - Required: rd_req and its fields stable for all 7 cycles; rd_req=0 the cycle after rd_ack.
- Reset mid-frame:
  - Stimulus: rst_133 low during WAIT_DONE.
  - Required: all outputs reset immediately; after release, no vga_rise and no rd_req until a new frame_start edge.
